// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: I2C bit-clock generator producing quarter-period strobes and a
// registered SCL level in the clk domain. Four runtime-selectable bus rates.
// Optional slave clock stretching is built when I2C_SCL_STRETCH_EN is defined;
// without it scl_in is ignored and every period is exactly 4Q cycles.
module i2c_scl_gen #(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int RATE0_HZ      = 10000,
  parameter int RATE1_HZ      = 100000,
  parameter int RATE2_HZ      = 400000,
  parameter int RATE3_HZ      = 1000000,
  parameter int CNT_W         = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] rate_sel,
  input  logic       scl_in,
  output logic       scl_level,
  output logic [1:0] phase,
  output logic       quarter_tick,
  output logic       drive_strobe,
  output logic       sample_strobe,
  output logic       period_done,
  output logic       stretching,
  output logic       busy
);

  localparam int Q0 = CLK_FREQUENCY / (4 * RATE0_HZ);
  localparam int Q1 = CLK_FREQUENCY / (4 * RATE1_HZ);
  localparam int Q2 = CLK_FREQUENCY / (4 * RATE2_HZ);
  localparam int Q3 = CLK_FREQUENCY / (4 * RATE3_HZ);
  localparam int Q_LIM = 1 << CNT_W;

  // A quarter must be at least two cycles and its last count must fit in cnt.
  generate
    if (Q0 < 2 || Q1 < 2 || Q2 < 2 || Q3 < 2 ||
        Q0 >= Q_LIM || Q1 >= Q_LIM || Q2 >= Q_LIM || Q3 >= Q_LIM) begin : g_bad_q
      $error("i2c_scl_gen: quarter count out of range for CNT_W");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, q_last;
  logic [1:0]       phase_nx, ph_inc, rate_q, rate_nx;
  logic             scl_nx, hold;

`ifdef I2C_SCL_STRETCH_EN
  logic [1:0] sync_pipe;
  logic       scl_sync;

  // Two-flop synchronizer for the asynchronous bus SCL; idles released-high.
  always_ff @(posedge clk) begin
    if (reset) sync_pipe <= 2'b11;
    else       sync_pipe <= {sync_pipe[0], scl_in};
  end
  assign scl_sync = sync_pipe[1];
  // Only the first cycle of the high phase can be held: cnt stays at 0 there.
  assign hold = (state == RUN) && (phase == 2'd2) && scl_level && !scl_sync;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold = 1'b0;
`endif

  // Last count of the quarter for the rate latched at the period start.
  always_comb begin
    case (rate_q)
      2'd0:    q_last = CNT_W'(Q0 - 1);
      2'd1:    q_last = CNT_W'(Q1 - 1);
      2'd2:    q_last = CNT_W'(Q2 - 1);
      default: q_last = CNT_W'(Q3 - 1);
    endcase
  end

  assign busy          = (state == RUN);
  assign stretching    = hold;
  assign quarter_tick  = busy && !hold && (cnt == q_last);
  assign drive_strobe  = quarter_tick && (phase == 2'd0);
  assign sample_strobe = quarter_tick && (phase == 2'd2);
  assign period_done   = quarter_tick && (phase == 2'd3);
  assign ph_inc        = phase + 2'd1;

  // Next-state: quarter counting, phase advance, rate latch and SCL level.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    phase_nx = phase;
    rate_nx  = rate_q;
    scl_nx   = scl_level;
    case (state)
      IDLE: begin
        cnt_nx   = '0;
        phase_nx = 2'd0;
        scl_nx   = 1'b1;
        if (enable) begin
          state_nx = RUN;
          rate_nx  = rate_sel;
          scl_nx   = 1'b0;
        end
      end
      default: begin
        if (!enable) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          phase_nx = 2'd0;
          scl_nx   = 1'b1;
        end else if (hold) begin
          cnt_nx = '0;
        end else if (quarter_tick) begin
          cnt_nx   = '0;
          phase_nx = ph_inc;
          scl_nx   = ph_inc[1];
          if (phase == 2'd3) rate_nx = rate_sel;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
    endcase
  end

  // State register; reset returns to IDLE with SCL released and rate 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      phase     <= 2'd0;
      rate_q    <= 2'd1;
      scl_level <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      phase     <= phase_nx;
      rate_q    <= rate_nx;
      scl_level <= scl_nx;
    end
  end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Bench for i2c_scl_gen: a period-position model checked every cycle plus
// hand-computed timing expectations for the directed scenarios.
module tb_i2c_scl_gen;

`ifdef I2C_SCL_STRETCH_EN
  localparam bit STR = 1'b1;
`else
  localparam bit STR = 1'b0;
`endif
  // With SCL looped back, the synchronizer delay holds the high phase 2 cycles.
  localparam int SX = STR ? 2 : 0;

  logic       clk = 1'b0;
  logic       reset, enable, slave_low;
  logic [1:0] rate_sel;
  logic       scl_in;
  logic       scl_level, quarter_tick, drive_strobe, sample_strobe;
  logic       period_done, stretching, busy;
  logic [1:0] phase;

  assign scl_in = scl_level & ~slave_low;

  i2c_scl_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .rate_sel(rate_sel),
    .scl_in(scl_in), .scl_level(scl_level), .phase(phase),
    .quarter_tick(quarter_tick), .drive_strobe(drive_strobe),
    .sample_strobe(sample_strobe), .period_done(period_done),
    .stretching(stretching), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: position within the current period (0..4Q-1) plus synchronizer history.
  bit m_run, m_s1, m_s2, m_valid;
  int m_pos, m_rate;

  function automatic int qof(input int r);
    int hz;
    case (r)
      0: hz = 10000;
      1: hz = 100000;
      2: hz = 400000;
      default: hz = 1000000;
    endcase
    return 50000000 / (4 * hz);
  endfunction

  function automatic bit m_hold();
    return STR && m_run && (m_pos == 2 * qof(m_rate)) && !m_s2;
  endfunction

  function automatic bit m_scl();
    return m_run ? (m_pos >= 2 * qof(m_rate)) : 1'b1;
  endfunction

  always @(posedge clk) begin
    bit h, sin;
    int q;
    h   = m_hold();
    sin = m_scl() & ~slave_low;
    q   = qof(m_rate);
    if (reset) begin
      m_run = 0; m_pos = 0; m_rate = 1; m_s1 = 1; m_s2 = 1; m_valid = 1;
    end else begin
      m_s2 = m_s1;
      m_s1 = sin;
      if (!m_run) begin
        if (enable) begin m_run = 1; m_pos = 0; m_rate = int'(rate_sel); end
      end else if (!enable) begin
        m_run = 0; m_pos = 0;
      end else if (!h) begin
        if (m_pos == 4 * q - 1) begin m_pos = 0; m_rate = int'(rate_sel); end
        else m_pos = m_pos + 1;
      end
    end
  end

  int checks = 0, failures = 0, str_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc=%0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance to the next negedge and compare every output against the model.
  task automatic step();
    int q, ph;
    bit tk, eh;
    logic [8:0] ex, ac;
    @(negedge clk);
    if (m_valid) begin
      q  = qof(m_rate);
      eh = m_hold();
      ph = m_run ? m_pos / q : 0;
      tk = m_run && !eh && (m_pos % q == q - 1);
      ex = {m_scl(), ph[1:0], tk, tk && ph == 0, tk && ph == 2, tk && ph == 3, eh, m_run};
      ac = {scl_level, phase, quarter_tick, drive_strobe, sample_strobe,
            period_done, stretching, busy};
      checks++;
      if (ac !== ex) begin
        failures++;
        $display("FAIL cycle_model cyc=%0d got=%b expected=%b", cyc, ac, ex);
      end
    end
    if (stretching) str_cnt++;
  endtask

  function automatic bit sel(input int w);
    case (w)
      0: return drive_strobe;
      1: return sample_strobe;
      2: return period_done;
      3: return (phase == 2'd1) && quarter_tick;
      default: return (phase == 2'd1);
    endcase
  endfunction

  task automatic wait_sig(input int w, input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (sel(w)) begin t = cyc; break; end
    end
    if (t < 0) begin
      checks++;
      failures++;
      $display("FAIL timeout_sel%0d: got none expected event within %0d cycles", w, bound);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_scl"}, int'(scl_level), 1);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_phase"}, int'(phase), 0);
    chk({nm, "_strobes"}, int'({quarter_tick, drive_strobe, sample_strobe,
                                period_done, stretching}), 0);
  endtask

  initial begin
    int t0, t, td, td2, td3, td4, td5, td6, s0, nstb;
    reset = 1'b1; enable = 1'b0; rate_sel = 2'd1; slave_low = 1'b0;
    repeat (3) step();
    chk_idle("reset");
    reset = 1'b0;
    repeat (2) step();

    // Rate 1: strobes at 125 / 375 / 500 after the enable edge.
    enable = 1'b1;
    step();
    t0 = cyc;
    chk("start_scl_low", int'(scl_level), 0);
    chk("start_busy", int'(busy), 1);
    wait_sig(0, 600, t);  chk("r1_drive", t - t0, 124);
    wait_sig(1, 600, t);  chk("r1_sample", t - t0, 374 + SX);
    wait_sig(2, 600, td); chk("r1_done", td - t0, 499 + SX);
    wait_sig(2, 600, t);  chk("r1_period", t - td, 500 + SX);
    td = t;

    // Rate change mid-period takes effect only at the next period.
    repeat (200) step();
    rate_sel = 2'd2;
    wait_sig(2, 600, td2); chk("switch_cur_period", td2 - td, 500 + SX);
    wait_sig(2, 600, td3); chk("r2_period", td3 - td2, 124 + SX);
    rate_sel = 2'd3;
    wait_sig(2, 600, td4); chk("r3_period", td4 - td3, 48 + SX);
    rate_sel = 2'd1;
    wait_sig(2, 600, td5); chk("back_r1_period", td5 - td4, 500 + SX);

    // Slave holds SCL low for 40 cycles from phase-2 entry.
    wait_sig(3, 600, t);
    s0 = str_cnt;
    slave_low = 1'b1;
    repeat (40) step();
    slave_low = 1'b0;
    wait_sig(2, 700, td6);
    chk("stretch_period", td6 - td5, STR ? 541 : 500);
    chk("stretch_cycles", str_cnt - s0, STR ? 41 : 0);

    // Abort at cycle 300, stay idle, then restart cleanly.
    repeat (300) step();
    enable = 1'b0;
    step();
    chk_idle("abort");
    nstb = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (quarter_tick || drive_strobe || sample_strobe || period_done) nstb++;
    end
    chk("idle_no_strobes", nstb, 0);
    enable = 1'b1;
    step();
    t0 = cyc;
    chk("restart_scl", int'(scl_level), 0);
    chk("restart_phase", int'(phase), 0);
    wait_sig(0, 600, t); chk("restart_drive", t - t0, 124);

    // One-cycle enable drop: back to idle, then a fresh start next edge.
    enable = 1'b0;
    step();
    chk("drop_busy", int'(busy), 0);
    enable = 1'b1;
    step();
    chk("redo_busy", int'(busy), 1);
    chk("redo_phase", int'(phase), 0);

    // Reset mid phase 1; restart only via enable at the newly selected rate.
    wait_sig(4, 600, t);
    repeat (10) step();
    reset = 1'b1; enable = 1'b0; rate_sel = 2'd3;
    step();
    chk_idle("midreset");
    reset = 1'b0;
    repeat (5) step();
    chk("post_reset_idle", int'(busy), 0);
    enable = 1'b1;
    step();
    t0 = cyc;
    wait_sig(2, 200, t); chk("post_reset_r3_done", t - t0, 47 + SX);
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
